draw_sequencer: RTL and testbench
=================================

DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
REQ-001 SCREEN_W, default 160, screen width in pixels.
REQ-002 SCREEN_H, default 120, screen height in pixels.
REQ-003 SPRITE_SZ, default 40, sprite side length in pixels.
REQ-004 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request to begin one draw pass.
REQ-007 fullScreen  input  1  1 = full-screen pass; 0 = sprite pass.
REQ-008 black  input  1  1 = paint black regardless of memSelIn.
REQ-009 xInitSel  input  4  sprite x-origin select, same encoding as the x-origin table (REQ-030).
REQ-010 yInitSel  input  2  sprite y-origin select: 00 -> 0, 01 -> 30, others -> 0.
REQ-011 memSelIn  input  5  image memory select for this pass.
REQ-012 x  output  8  current pixel x.
REQ-013 y  output  7  current pixel y.
REQ-014 plot  output  1  x, y and color select are valid this cycle.
REQ-015 memSel  output  5  memory select latched for the pass.
REQ-016 blackOut  output  1  black flag latched for the pass.
REQ-017 busy  output  1  pass in progress.
REQ-018 done  output  1  one-cycle pulse after the last pixel.

Function
REQ-019 FSM states: IDLE, LOAD, DRAW, DONE.
REQ-020 In IDLE, start=1 SHALL move the FSM to LOAD and latch fullScreen, black, memSelIn, xInitSel and yInitSel.
REQ-021 LOAD SHALL last one cycle: set x0/y0 to 0/0 for a full-screen pass or to the table origin for a sprite pass; set x=x0, y=y0; then go to DRAW.
REQ-022 DRAW SHALL assert plot every cycle and scan row-major: x+1 per cycle; at x=x0+W-1, x SHALL wrap to x0 and y SHALL increment.
REQ-023 W×H SHALL be SCREEN_W×SCREEN_H for a full-screen pass and SPRITE_SZ×SPRITE_SZ for a sprite pass.
REQ-024 When the pixel at (x0+W-1, y0+H-1) is plotted, the next state SHALL be DONE.
REQ-025 DONE SHALL assert done for one cycle with plot=0, then return to IDLE.
REQ-026 First plot SHALL occur 2 cycles after start is sampled; a pass SHALL plot exactly W·H pixels in W·H consecutive cycles.
REQ-027 busy SHALL be 1 in LOAD, DRAW and DONE.
REQ-028 start SHALL be ignored outside IDLE; start held high SHALL cause back-to-back passes separated by DONE and one IDLE cycle.
REQ-029 Coordinate arithmetic SHALL use 9-bit x and 8-bit y internally; outputs SHALL be truncated. The x-origin table guarantees x0+SPRITE_SZ ≤ SCREEN_W.
REQ-030 x-origin table: 0000->0, 0001..0111 -> 36,30,24,18,12,6,0; 1000..1101 -> 90,96,102,108,114,120; others -> 0.

Reset
REQ-031 Reset SHALL force IDLE immediately, including mid-pass, with x=0, y=0, plot=0, busy=0, done=0, memSel=0, blackOut=0.
REQ-032 After a mid-pass reset, no further pixels of that pass SHALL be plotted.

Configuration
REQ-033 DRAW_ABORT_EN defined: add input abort (1 bit); abort=1 in LOAD or DRAW SHALL drop plot in the same cycle, enter DONE, and pulse done.
REQ-034 DRAW_ABORT_EN undefined: no abort port; every started pass SHALL complete.

Structure
REQ-035 A shared package SHALL hold SCREEN_W/H, SPRITE_SZ, the state enum and the origin-table constants.
REQ-036 One sub-module, draw_origin_lut, SHALL map the select inputs to x0/y0 combinationally.

Verification
REQ-037 fullScreen=1, black=1, start pulse -> first plot at (0,0) two cycles later; 19200 plots; last at (159,119); done one cycle after the last plot.
REQ-038 Sprite pass, xInitSel=1101, yInitSel=01 -> plots (120,30)..(159,69); 1600 plots; row wrap from (159,30) to (120,31).
REQ-039 Sprite pass, xInitSel=0001, memSelIn=01010 -> memSel=01010 and blackOut=0 on every plot; start pulses mid-pass do not change the pixel count.
REQ-040 Reset asserted at plot 500 of a sprite pass -> plot, busy and done go to 0 asynchronously; the next start restarts at the origin.
REQ-041 start held high for two passes -> 1600 plots, done, idle, LOAD, 1600 plots.
REQ-042 DRAW_ABORT_EN: abort at plot 100 -> plot stops that cycle, done pulses once, busy drops after DONE.

Source files
------------

// File: rtl/draw_sequencer_pkg.sv
// Shared constants for the draw sequencer: screen/sprite geometry, FSM states, origin table.
package draw_sequencer_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int SPRITE_SZ = 40;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DRAW = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Sprite x-origin per select code, listed from code 15 down to code 0.
  localparam logic [15:0][8:0] X_ORIGIN_TBL = {
    9'd0,   9'd0,   9'd120, 9'd114, 9'd108, 9'd102, 9'd96, 9'd90,
    9'd0,   9'd6,   9'd12,  9'd18,  9'd24,  9'd30,  9'd36, 9'd0
  };

  localparam logic [7:0] Y_ORIGIN_1 = 8'd30;

endpackage

// File: rtl/draw_origin_lut.sv
// Combinational map from the latched sprite selects to the sprite origin (x0, y0).
module draw_origin_lut
  import draw_sequencer_pkg::*;
(
  input  logic [3:0] xsel_i,
  input  logic [1:0] ysel_i,
  output logic [8:0] x0_o,
  output logic [7:0] y0_o
);

  always_comb begin
    x0_o = X_ORIGIN_TBL[xsel_i];
    y0_o = (ysel_i == 2'b01) ? Y_ORIGIN_1 : 8'd0;
  end

endmodule

// File: rtl/draw_sequencer.sv
// Row-major pixel scanner for full-screen or sprite passes; first plot two cycles after start.
// Optional DRAW_ABORT_EN adds an abort input that ends the pass early through DONE.
module draw_sequencer #(
  parameter int SCREEN_W  = draw_sequencer_pkg::SCREEN_W,
  parameter int SCREEN_H  = draw_sequencer_pkg::SCREEN_H,
  parameter int SPRITE_SZ = draw_sequencer_pkg::SPRITE_SZ
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       fullScreen,
  input  logic       black,
  input  logic [3:0] xInitSel,
  input  logic [1:0] yInitSel,
  input  logic [4:0] memSelIn,
`ifdef DRAW_ABORT_EN
  input  logic       abort,
`endif
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       plot,
  output logic [4:0] memSel,
  output logic       blackOut,
  output logic       busy,
  output logic       done
);

  typedef draw_sequencer_pkg::state_e state_e;
  localparam state_e IDLE = draw_sequencer_pkg::ST_IDLE;
  localparam state_e LOAD = draw_sequencer_pkg::ST_LOAD;
  localparam state_e DRAW = draw_sequencer_pkg::ST_DRAW;
  localparam state_e DONE = draw_sequencer_pkg::ST_DONE;

  state_e     state_q, state_d;
  logic       full_q, black_q;
  logic [4:0] mem_q;
  logic [3:0] xsel_q;
  logic [1:0] ysel_q;
  logic [8:0] x_q, x_d, x0_q, x0_d, lut_x0, w;
  logic [7:0] y_q, y_d, y0_q, y0_d, lut_y0, h;
  logic       row_end, last_px, abort_w;

`ifdef DRAW_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  draw_origin_lut u_origin_lut (
    .xsel_i (xsel_q),
    .ysel_i (ysel_q),
    .x0_o   (lut_x0),
    .y0_o   (lut_y0)
  );

  assign w       = full_q ? 9'(SCREEN_W) : 9'(SPRITE_SZ);
  assign h       = full_q ? 8'(SCREEN_H) : 8'(SPRITE_SZ);
  assign row_end = (x_q == x0_q + w - 9'd1);
  assign last_px = row_end && (y_q == y0_q + h - 8'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = abort_w ? DONE : DRAW;
      DRAW:    if (abort_w || last_px) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    plot = (state_q == DRAW) && !abort_w;
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    x0_d = x0_q;
    y0_d = y0_q;
    if (state_q == LOAD) begin
      x0_d = full_q ? 9'd0 : lut_x0;
      y0_d = full_q ? 8'd0 : lut_y0;
      x_d  = x0_d;
      y_d  = y0_d;
    end else if (state_q == DRAW && !abort_w) begin
      if (row_end) begin
        x_d = x0_q;
        y_d = y_q + 8'd1;
      end else begin
        x_d = x_q + 9'd1;
      end
    end
  end

  // Pass attributes are captured only when a start is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      full_q  <= 1'b0;
      black_q <= 1'b0;
      mem_q   <= '0;
      xsel_q  <= '0;
      ysel_q  <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      x0_q <= x0_d;
      y0_q <= y0_d;
      if (state_q == IDLE && start) begin
        full_q  <= fullScreen;
        black_q <= black;
        mem_q   <= memSelIn;
        xsel_q  <= xInitSel;
        ysel_q  <= yInitSel;
      end
    end
  end

  assign x        = x_q[7:0];
  assign y        = y_q[6:0];
  assign memSel   = mem_q;
  assign blackOut = black_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: full-screen and sprite passes, origin table, reset, back-to-back.
module tb_draw_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       fullScreen;
  logic       black;
  logic [3:0] xInitSel;
  logic [1:0] yInitSel;
  logic [4:0] memSelIn;
`ifdef DRAW_ABORT_EN
  logic       abort;
`endif
  logic [7:0] x;
  logic [6:0] y;
  logic       plot;
  logic [4:0] memSel;
  logic       blackOut;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  draw_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .fullScreen (fullScreen),
    .black      (black),
    .xInitSel   (xInitSel),
    .yInitSel   (yInitSel),
    .memSelIn   (memSelIn),
`ifdef DRAW_ABORT_EN
    .abort      (abort),
`endif
    .x          (x),
    .y          (y),
    .plot       (plot),
    .memSel     (memSel),
    .blackOut   (blackOut),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Walks one pass at negedges; cycle 1 is the cycle after start is sampled.
  // mode: 0 drop start, 1 hold start, 2 extra start pulses mid-pass.
  task automatic run_pass(input int x0, input int y0, input int w, input int h, input int mode,
                          input logic [4:0] exp_mem, input logic exp_black,
                          output int nplots, output int first_cyc, output int done_cyc,
                          output int fx, output int fy, output int lx, output int ly,
                          output int seq_err, output int attr_err);
    int ex, ey;
    logic [7:0] exb;
    logic [6:0] eyb;
    nplots = 0; first_cyc = -1; done_cyc = -1;
    fx = -1; fy = -1; lx = -1; ly = -1;
    seq_err = 0; attr_err = 0;
    ex = x0; ey = y0;
    for (int cyc = 1; cyc <= w * h + 20; cyc++) begin
      @(negedge clk);
      case (mode)
        1:       start = 1'b1;
        2:       start = (cyc >= 50 && cyc < 55) || (cyc >= 700 && cyc < 702);
        default: start = 1'b0;
      endcase
      if (plot === 1'b1) begin
        if (nplots == 0) begin
          first_cyc = cyc; fx = int'(x); fy = int'(y);
        end
        exb = ex[7:0];
        eyb = ey[6:0];
        if (x !== exb || y !== eyb) seq_err++;
        if (memSel !== exp_mem || blackOut !== exp_black) attr_err++;
        lx = int'(x); ly = int'(y);
        nplots++;
        ex++;
        if (ex == x0 + w) begin
          ex = x0; ey++;
        end
      end
      if (done === 1'b1) begin
        if (plot !== 1'b0) seq_err++;
        done_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (plot !== 1'b0) begin errors++; $display("FAIL reset_plot got=%b exp=0", plot); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (x !== 8'd0 || y !== 7'd0) begin errors++; $display("FAIL reset_xy got=(%0d,%0d) exp=(0,0)", x, y); end
    checks++; if (memSel !== 5'd0 || blackOut !== 1'b0) begin errors++; $display("FAIL reset_attr got=%b/%b exp=00000/0", memSel, blackOut); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_fullscreen();
    int n, fc, dc, fx, fy, lx, ly, se, ae;
    fullScreen = 1'b1; black = 1'b1; memSelIn = 5'b00011; xInitSel = 4'b1101; yInitSel = 2'b01;
    start = 1'b1;
    run_pass(0, 0, 160, 120, 0, 5'b00011, 1'b1, n, fc, dc, fx, fy, lx, ly, se, ae);
    checks++; if (n != 19200) begin errors++; $display("FAIL full_count got=%0d exp=19200", n); end
    checks++; if (fc != 2) begin errors++; $display("FAIL full_first_latency got=%0d exp=2", fc); end
    checks++; if (fx != 0 || fy != 0) begin errors++; $display("FAIL full_first got=(%0d,%0d) exp=(0,0)", fx, fy); end
    checks++; if (lx != 159 || ly != 119) begin errors++; $display("FAIL full_last got=(%0d,%0d) exp=(159,119)", lx, ly); end
    checks++; if (dc != 19202) begin errors++; $display("FAIL full_done_cycle got=%0d exp=19202", dc); end
    checks++; if (se != 0) begin errors++; $display("FAIL full_scan_order got=%0d exp=0", se); end
    checks++; if (ae != 0) begin errors++; $display("FAIL full_attr got=%0d exp=0", ae); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL full_after got=%b%b exp=00", busy, done); end
  endtask

  task automatic test_sprite_origin();
    int n, fc, dc, fx, fy, lx, ly, se, ae;
    fullScreen = 1'b0; black = 1'b0; memSelIn = 5'b00001; xInitSel = 4'b1101; yInitSel = 2'b01;
    start = 1'b1;
    run_pass(120, 30, 40, 40, 0, 5'b00001, 1'b0, n, fc, dc, fx, fy, lx, ly, se, ae);
    checks++; if (n != 1600) begin errors++; $display("FAIL sprite_count got=%0d exp=1600", n); end
    checks++; if (fx != 120 || fy != 30) begin errors++; $display("FAIL sprite_first got=(%0d,%0d) exp=(120,30)", fx, fy); end
    checks++; if (lx != 159 || ly != 69) begin errors++; $display("FAIL sprite_last got=(%0d,%0d) exp=(159,69)", lx, ly); end
    checks++; if (se != 0) begin errors++; $display("FAIL sprite_wrap got=%0d exp=0", se); end
    checks++; if (dc != 1602) begin errors++; $display("FAIL sprite_done_cycle got=%0d exp=1602", dc); end
    @(negedge clk);
  endtask

  task automatic test_sprite_attr();
    int n, fc, dc, fx, fy, lx, ly, se, ae;
    fullScreen = 1'b0; black = 1'b0; memSelIn = 5'b01010; xInitSel = 4'b0001; yInitSel = 2'b00;
    start = 1'b1;
    run_pass(36, 0, 40, 40, 2, 5'b01010, 1'b0, n, fc, dc, fx, fy, lx, ly, se, ae);
    memSelIn = 5'b11111; black = 1'b1;
    checks++; if (n != 1600) begin errors++; $display("FAIL attr_count got=%0d exp=1600", n); end
    checks++; if (ae != 0) begin errors++; $display("FAIL attr_memsel got=%0d exp=0", ae); end
    checks++; if (lx != 75 || ly != 39) begin errors++; $display("FAIL attr_last got=(%0d,%0d) exp=(75,39)", lx, ly); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL attr_idle got=%b exp=0", busy); end
  endtask

  task automatic test_origin_table();
    logic [3:0] xs [4] = '{4'b0111, 4'b1000, 4'b0100, 4'b1110};
    logic [1:0] ys [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    int ex0 [4] = '{0, 90, 18, 0};
    int ey0 [4] = '{0, 0, 30, 0};
    int n, fc, dc, fx, fy, lx, ly, se, ae;
    for (int i = 0; i < 4; i++) begin
      fullScreen = 1'b0; black = 1'b0; memSelIn = 5'd7; xInitSel = xs[i]; yInitSel = ys[i];
      start = 1'b1;
      run_pass(ex0[i], ey0[i], 40, 40, 0, 5'd7, 1'b0, n, fc, dc, fx, fy, lx, ly, se, ae);
      checks++;
      if (fx != ex0[i] || fy != ey0[i] || n != 1600 || se != 0) begin
        errors++;
        $display("FAIL origin_%0d got=(%0d,%0d) n=%0d seq=%0d exp=(%0d,%0d) n=1600 seq=0", i, fx, fy, n, se, ex0[i], ey0[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midpass();
    int cnt, after;
    int n, fc, dc, fx, fy, lx, ly, se, ae;
    fullScreen = 1'b0; black = 1'b0; memSelIn = 5'b00100; xInitSel = 4'b0001; yInitSel = 2'b00;
    start = 1'b1;
    cnt = 0;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (plot === 1'b1) cnt++;
      if (cnt == 500) break;
    end
    checks++; if (cnt != 500) begin errors++; $display("FAIL midreset_reach got=%0d exp=500", cnt); end
    reset = 1'b1;
    #1;
    checks++; if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midreset_async got=plot%b busy%b done%b exp=000", plot, busy, done);
    end
    checks++; if (x !== 8'd0 || y !== 7'd0 || memSel !== 5'd0) begin
      errors++; $display("FAIL midreset_regs got=(%0d,%0d) mem=%b exp=(0,0) mem=00000", x, y, memSel);
    end
    @(negedge clk);
    reset = 1'b0;
    after = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (plot !== 1'b0 || busy !== 1'b0) after++;
    end
    checks++; if (after != 0) begin errors++; $display("FAIL midreset_quiet got=%0d exp=0", after); end
    start = 1'b1;
    run_pass(36, 0, 40, 40, 0, 5'b00100, 1'b0, n, fc, dc, fx, fy, lx, ly, se, ae);
    checks++; if (fx != 36 || fy != 0 || n != 1600) begin
      errors++; $display("FAIL midreset_restart got=(%0d,%0d) n=%0d exp=(36,0) n=1600", fx, fy, n);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n, fc, dc, fx, fy, lx, ly, se, ae;
    fullScreen = 1'b0; black = 1'b1; memSelIn = 5'b10001; xInitSel = 4'b1000; yInitSel = 2'b01;
    start = 1'b1;
    run_pass(90, 30, 40, 40, 1, 5'b10001, 1'b1, n, fc, dc, fx, fy, lx, ly, se, ae);
    checks++; if (n != 1600 || dc != 1602) begin errors++; $display("FAIL b2b_pass1 got=n%0d done@%0d exp=n1600 done@1602", n, dc); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || plot !== 1'b0) begin errors++; $display("FAIL b2b_idle got=busy%b plot%b exp=00", busy, plot); end
    run_pass(90, 30, 40, 40, 1, 5'b10001, 1'b1, n, fc, dc, fx, fy, lx, ly, se, ae);
    checks++; if (n != 1600 || fc != 2 || se != 0) begin
      errors++; $display("FAIL b2b_pass2 got=n%0d first@%0d seq%0d exp=n1600 first@2 seq0", n, fc, se);
    end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stop got=%b exp=0", busy); end
  endtask

`ifdef DRAW_ABORT_EN
  task automatic test_abort();
    int cnt;
    fullScreen = 1'b0; black = 1'b0; memSelIn = 5'd2; xInitSel = 4'b0000; yInitSel = 2'b00;
    start = 1'b1;
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (plot === 1'b1) cnt++;
      if (cnt == 100) break;
    end
    abort = 1'b1;
    #1;
    checks++; if (plot !== 1'b0) begin errors++; $display("FAIL abort_plot got=%b exp=0", plot); end
    @(negedge clk);
    abort = 1'b0;
    checks++; if (done !== 1'b1 || plot !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_done got=done%b plot%b busy%b exp=101", done, plot, busy);
    end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle got=done%b busy%b exp=00", done, busy); end
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; fullScreen = 1'b0; black = 1'b0;
    xInitSel = 4'd0; yInitSel = 2'd0; memSelIn = 5'd0;
`ifdef DRAW_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_fullscreen();
    test_sprite_origin();
    test_sprite_attr();
    test_origin_table();
    test_reset_midpass();
    test_back_to_back();
`ifdef DRAW_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
